// File: rtl/braille_sequencer.sv
// Shows a 4-digit BCD word as a Braille number sign plus four digits, each held then blanked.
// Registered outputs follow the state one cycle after acceptance; in_ready is high only in IDLE, abort cancels.
module braille_sequencer #(
  parameter int unsigned HOLD_CYCLES = 1000,
  parameter int unsigned GAP_CYCLES  = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_bcd,
  input  logic        abort,
  output logic [3:0]  digit,
  output logic        cell_on,
  output logic        num_sign,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SIGN     = 3'd1,
    SIGN_GAP = 3'd2,
    DIG      = 3'd3,
    DIG_GAP  = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [15:0] word, word_nxt;
  logic        done_nxt, err_nxt;
  logic        cell_on_nxt, num_sign_nxt, busy_nxt;
  logic [3:0]  digit_nxt;

  function automatic logic bcd_ok(input logic [15:0] w);
    for (int i = 0; i < 4; i++) begin
      if (w[i*4 +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    word_nxt  = word;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = 16'd0;
        if (in_valid && !abort) begin
          if (bcd_ok(in_bcd)) begin
            word_nxt  = in_bcd;
            idx_nxt   = 2'd3;
            state_nxt = SIGN;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      SIGN: begin
        if (cnt == HOLD_LAST) begin
          cnt_nxt   = 16'd0;
          state_nxt = SIGN_GAP;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      SIGN_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt   = 16'd0;
          state_nxt = DIG;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      DIG: begin
        if (cnt == HOLD_LAST) begin
          cnt_nxt   = 16'd0;
          state_nxt = DIG_GAP;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      DIG_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt = 16'd0;
          if (idx != 2'd0) begin
            idx_nxt   = idx - 2'd1;
            state_nxt = DIG;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 16'd0;
      end
    endcase

    // Abort outranks a normal finish landing on the same edge.
    if (state != IDLE && abort) begin
      state_nxt = IDLE;
      cnt_nxt   = 16'd0;
      done_nxt  = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    cell_on_nxt  = (state_nxt == SIGN) || (state_nxt == DIG);
    num_sign_nxt = (state_nxt == SIGN);
    busy_nxt     = (state_nxt != IDLE);
    digit_nxt    = 4'd0;
    if (state_nxt == DIG) digit_nxt = word_nxt[{idx_nxt, 2'b00} +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 16'd0;
      idx      <= 2'd0;
      word     <= 16'd0;
      digit    <= 4'd0;
      cell_on  <= 1'b0;
      num_sign <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      word     <= word_nxt;
      digit    <= digit_nxt;
      cell_on  <= cell_on_nxt;
      num_sign <= num_sign_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
    end
  end

  assign in_ready = (state == IDLE);

endmodule

// File: tb/tb_braille_sequencer.sv
// Directed bench for braille_sequencer with HOLD_CYCLES=3, GAP_CYCLES=2; cycle 1 is the cycle after acceptance.
module tb_braille_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] in_bcd = 16'h0000;
  logic        in_ready;
  logic [3:0]  digit;
  logic        cell_on, num_sign, busy, done, err;

  int n_assert = 0;
  int n_fail   = 0;

  braille_sequencer #(.HOLD_CYCLES(3), .GAP_CYCLES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_bcd   (in_bcd),
    .abort    (abort),
    .digit    (digit),
    .cell_on  (cell_on),
    .num_sign (num_sign),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_on, input logic e_ns,
                         input logic [3:0] e_dg, input logic e_bz,
                         input logic e_dn, input logic e_rdy);
    chk({tag, ".cell_on"},  16'(cell_on),  16'(e_on));
    chk({tag, ".num_sign"}, 16'(num_sign), 16'(e_ns));
    chk({tag, ".digit"},    16'(digit),    16'(e_dg));
    chk({tag, ".busy"},     16'(busy),     16'(e_bz));
    chk({tag, ".done"},     16'(done),     16'(e_dn));
    chk({tag, ".in_ready"}, 16'(in_ready), 16'(e_rdy));
  endtask

  initial begin
    logic       e_on, e_ns, e_bz, e_dn, e_rdy;
    logic [3:0] e_dg;

    // Reset values before any clock edge.
    #2;
    chk_all("reset", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    chk("reset.err", 16'(err), 16'd0);

    // Word 1905, offered on the first edge after reset release.
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_bcd   = 16'h1905;
    for (int c = 1; c <= 27; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
      e_on  = c inside {[1:3], [6:8], [11:13], [16:18], [21:23]};
      e_ns  = c inside {[1:3]};
      e_dg  = (c inside {[6:8]})   ? 4'd1 :
              (c inside {[11:13]}) ? 4'd9 :
              (c inside {[21:23]}) ? 4'd5 : 4'd0;
      e_bz  = (c <= 25);
      e_dn  = (c == 26);
      e_rdy = (c >= 26);
      chk_all($sformatf("w1905.c%0d", c), e_on, e_ns, e_dg, e_bz, e_dn, e_rdy);
    end

    // Non-BCD nibble is rejected with a single err pulse.
    in_valid = 1'b1;
    in_bcd   = 16'h12A4;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bad.c1.err", 16'(err), 16'd1);
    chk_all("bad.c1", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("bad.c2.err", 16'(err), 16'd0);
    chk_all("bad.c2", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    // abort alongside in_valid in IDLE blocks acceptance.
    in_valid = 1'b1;
    in_bcd   = 16'h1234;
    abort    = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      chk_all($sformatf("idle_abort.c%0d", c), 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      chk($sformatf("idle_abort.c%0d.err", c), 16'(err), 16'd0);
    end
    in_valid = 1'b0;
    abort    = 1'b0;

    // Word 4321 aborted in cycle 7, then a new word taken on the next edge.
    in_valid = 1'b1;
    in_bcd   = 16'h4321;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
      if (c <= 7) begin
        e_on = c inside {[1:3], [6:7]};
        e_ns = c inside {[1:3]};
        e_dg = (c >= 6) ? 4'd4 : 4'd0;
        chk_all($sformatf("w4321.c%0d", c), e_on, e_ns, e_dg, 1'b1, 1'b0, 1'b0);
        if (c == 7) abort = 1'b1;
      end else begin
        chk_all("w4321.aborted", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("w4321.aborted.err", 16'(err), 16'd0);
        abort    = 1'b0;
        in_valid = 1'b1;
        in_bcd   = 16'h0007;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk_all("after_abort.c1", 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_all("after_abort.cancel", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    // 0000 then 9999 back to back with in_valid held; reset lands in 9999's second digit.
    in_valid = 1'b1;
    in_bcd   = 16'h0000;
    for (int c = 1; c <= 38; c++) begin
      @(negedge clk);
      if (c == 1) in_bcd = 16'h9999;
      if (c == 6)  chk_all("b2b.c6",  1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      if (c == 21) chk_all("b2b.c21", 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      if (c == 25) chk_all("b2b.c25", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      if (c == 26) chk_all("b2b.c26", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
      if (c == 27) begin
        chk_all("b2b.c27", 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
      end
      if (c == 32) chk_all("b2b.c32", 1'b1, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0);
      if (c == 38) begin
        chk_all("b2b.c38", 1'b1, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("async_rst.err", 16'(err), 16'd0);
      end
    end
    @(negedge clk);
    chk_all("rst_hold", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    // First edge after release accepts a word.
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_bcd   = 16'h0001;
    @(negedge clk);
    in_valid = 1'b0;
    chk_all("post_rst.c1", 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/braille_sequencer.md
BRAILLE_SEQUENCER -- requirements
Module: braille_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 1000: clock cycles each symbol is shown; legal range 1..65535.
REQ-002 Parameter GAP_CYCLES, default 200: blank clock cycles after each symbol; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  a 4-digit BCD word is offered on in_bcd.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 in_bcd  input  16  four BCD digits; [15:12] is the most significant digit and is shown first.
REQ-008 abort  input  1  synchronous request to cancel the word currently being shown.
REQ-009 digit  output  4  BCD code sent to the downstream Braille digit decoder.
REQ-010 cell_on  output  1  the Braille cell is lit; 0 blanks all dots.
REQ-011 num_sign  output  1  the cell shows the Braille number sign (dots 3-4-5-6) instead of a digit.
REQ-012 busy  output  1  a word is being sequenced.
REQ-013 done  output  1  one-cycle pulse: the word completed normally.
REQ-014 err  output  1  one-cycle pulse: the offered word was rejected.

Function
REQ-015 The block SHALL implement five states: IDLE, SIGN, SIGN_GAP, DIG, DIG_GAP. It SHALL keep a 16-bit cycle counter, a 2-bit digit index, and a 16-bit word register.
REQ-016 in_ready SHALL be 1 only in IDLE; busy SHALL be 1 in every state except IDLE.
REQ-017 Acceptance SHALL occur on a rising edge where in_valid=1, in_ready=1 and abort=0. Acceptance latches in_bcd, clears the counter, sets the index to 3, and enters SIGN.
REQ-018 If any nibble of in_bcd at acceptance is greater than 9, the block SHALL not latch the word, SHALL stay in IDLE, and SHALL pulse err for the next cycle only.
REQ-019 SIGN SHALL last exactly HOLD_CYCLES cycles with cell_on=1, num_sign=1 and digit=0. It then enters SIGN_GAP.
REQ-020 SIGN_GAP SHALL last exactly GAP_CYCLES cycles with cell_on=0, num_sign=0 and digit=0. It then enters DIG.
REQ-021 DIG SHALL last exactly HOLD_CYCLES cycles with cell_on=1, num_sign=0, and digit equal to the latched nibble selected by the index. It then enters DIG_GAP.
REQ-022 DIG_GAP SHALL last exactly GAP_CYCLES cycles with cell_on=0 and digit=0. At the end of DIG_GAP:
- index greater than 0: decrement the index and return to DIG;
- index equal to 0: enter IDLE and pulse done for the first IDLE cycle.
REQ-023 The counter SHALL clear on every state entry and SHALL never wrap; each state exits when the count reaches its duration minus 1.
REQ-024 A complete word SHALL occupy exactly 5*(HOLD_CYCLES+GAP_CYCLES) cycles, from the cycle after acceptance to the last DIG_GAP cycle inclusive.
REQ-025 In the done cycle in_ready SHALL be 1, so a new word can be accepted with zero idle cycles between words.
REQ-026 abort=1 in any non-IDLE state SHALL force IDLE at the next edge, with cell_on=0, no done pulse and no err pulse. abort in IDLE SHALL have no effect other than blocking acceptance.
REQ-027 The word register SHALL not change while busy=1; in_bcd and in_valid SHALL be ignored while busy.
REQ-028 All outputs SHALL be registered, with no combinational path from inputs to outputs, except in_ready, which is decoded from state.

Reset
REQ-029 rst_n=0 SHALL immediately, without a clock, force IDLE, counter=0, index=0, word register=0, digit=0, cell_on=0, num_sign=0, busy=0, done=0, err=0 and in_ready=1.
REQ-030 Reset asserted mid-word SHALL discard the word with no done pulse. The first acceptance SHALL be possible on the first rising edge after rst_n returns to 1.

Verification (HOLD_CYCLES=3, GAP_CYCLES=2; cycle 1 = first cycle after acceptance)
REQ-031 Accept 16'h1905 -> the following sequence:
- num_sign=1 for cycles 1-3, then blank for 4-5;
- digit=1 for 6-8, digit=9 for 11-13, digit=0 for 16-18, digit=5 for 21-23;
- cell_on=0 for 9-10, 14-15, 19-20 and 24-25;
- done=1 only in cycle 26, with in_ready=1.
REQ-032 Offer 16'h12A4 -> err=1 for exactly one cycle, busy stays 0, cell_on stays 0, no done.
REQ-033 Accept 16'h4321, then assert abort in cycle 7 -> IDLE in cycle 8, cell_on=0, busy=0, no done; a new word is accepted on the next edge.
REQ-034 Hold in_valid=1 with 16'h0000, then 16'h9999 back-to-back -> second acceptance occurs in the done cycle (cycle 26), and its SIGN starts in cycle 27.
REQ-035 Pull rst_n low asynchronously during DIG of the second digit -> all outputs reach their reset values before the next clock edge; no done pulse follows.
REQ-036 in_valid=1 together with abort=1 in IDLE -> no acceptance, in_ready stays 1, busy stays 0.
